core_ram_arbiter: RTL and testbench
===================================

CORE_RAM_ARBITER -- requirements
Module: core_ram_arbiter

Interface
REQ-001 Parameter INIT_ZERO, default 1, SHALL enable zero-fill of all 256 RAM locations after reset (0 = no fill).
REQ-002 RWCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 A_REQ  in  1  SHALL be the port-A access request, held until granted.
REQ-005 A_WE  in  1  SHALL select write (1) or read (0) for port A.
REQ-006 A_ADDR  in  8  SHALL be the port-A address.
REQ-007 A_WDATA  in  8  SHALL be the port-A write data.
REQ-008 A_GNT  out  1  SHALL mark the cycle in which the port-A access is issued to the RAM.
REQ-009 A_RVALID  out  1  SHALL mark valid port-A read data.
REQ-010 B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_RVALID SHALL mirror the port-A signals for port B with the same widths and meanings.
REQ-011 RDATA  out  8  SHALL be the shared read data, equal to RAM_RD.
REQ-012 BUSY  out  1  SHALL be high while zero-fill runs.
REQ-013 RAM_WEN, RAM_REN  out  1 each, and RAM_WADDR, RAM_RADDR, RAM_WD  out  8 each, SHALL drive the 256x8 RAM.
REQ-014 RAM_RD  in  8  SHALL be the RAM read data, registered by the RAM one cycle after RAM_REN.

Function
REQ-015 FSM states SHALL be INIT (zero-fill) and RUN.
REQ-016 In INIT:
- RAM_WEN=1, RAM_WADDR=fill counter, RAM_WD=0x00, RAM_REN=0.
- Counter SHALL run 0..255, one write per cycle.
- Transition to RUN SHALL occur after the write at address 255 (256 cycles total).
- No grants SHALL be issued; REQ inputs are ignored, and requests stay pending.
REQ-017 In RUN, BUSY SHALL be 0, and at most one grant SHALL be issued per cycle.
REQ-018 Grant decision SHALL be combinational from the REQ inputs and the priority pointer:
- single requester: granted in the same cycle;
- both requesting: the port not granted most recently wins.
REQ-019 The priority pointer SHALL update on every grant to favour the other port; idle cycles SHALL not change it.
REQ-020 Granted write: RAM_WEN=1, RAM_WADDR=ADDR, RAM_WD=WDATA, RAM_REN=0 in the grant cycle.
REQ-021 Granted read: RAM_REN=1, RAM_RADDR=ADDR, RAM_WEN=0 in the grant cycle.
REQ-022 Read RVALID SHALL assert for exactly one cycle, the cycle after the grant, on the granted port only; RDATA is valid in that cycle.
REQ-023 With no grant, RAM_WEN=0 and RAM_REN=0.
REQ-024 Back-to-back reads SHALL be supported at one per cycle, with RVALID pipelined (grant N, RVALID N+1).
REQ-025 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-026 Fill counter SHALL be 8 bits; termination SHALL be on count==255, with no wrap into a second pass.

Reset
REQ-027 On RESET assertion, asynchronously and at any point in an operation:
- state = INIT if INIT_ZERO=1, else RUN;
- fill counter = 0;
- pointer favours A;
- A_RVALID = B_RVALID = 0;
- BUSY = INIT_ZERO;
- grants and RAM enables SHALL be 0 while RESET is high.
REQ-028 A read granted just before RESET SHALL produce no RVALID after reset.

Verification
REQ-029 INIT_ZERO=1, release reset, A_REQ held high -> BUSY high 256 cycles, writes 0x00 to addresses 0..255; A_GNT first high in the cycle after BUSY falls.
REQ-030 A writes 0x5A to 0x10, then A reads 0x10 -> A_RVALID one cycle after the read grant with RDATA=0x5A; B_RVALID stays 0.
REQ-031 A and B request continuously -> grants alternate A,B,A,B; neither port is granted twice in a row.
REQ-032 Only B requests 4 back-to-back reads of 0x00..0x03 after fill -> B_GNT high 4 consecutive cycles; B_RVALID high the following 4 cycles with RDATA=0x00.
REQ-033 RESET pulsed at fill count 100 -> counter restarts at 0 and BUSY stays high for a full 256 cycles after release.
REQ-034 INIT_ZERO=0 -> BUSY=0 from reset, and a request is granted in the first cycle after reset release.

Source files
------------

// File: rtl/core_ram_arbiter.sv
// core_ram_arbiter: two-port round-robin arbiter in front of a single-port
// 256x8 synchronous RAM, with an optional zero-fill pass after reset.
//
// Handshake: a port raises X_REQ together with X_WE/X_ADDR/X_WDATA and holds
// all of them stable until X_GNT is seen high. The access is issued to the
// RAM in the X_GNT cycle itself. For a read, X_RVALID is high for exactly
// one cycle, the cycle after the grant, and RDATA carries the word then.
// REQ is ignored (left pending) while BUSY is high or RESET is asserted.
module core_ram_arbiter #(
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic       RWCLK,
  input  logic       RESET,
  // port A
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [7:0] A_ADDR,
  input  logic [7:0] A_WDATA,
  output logic       A_GNT,
  output logic       A_RVALID,
  // port B
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [7:0] B_ADDR,
  input  logic [7:0] B_WDATA,
  output logic       B_GNT,
  output logic       B_RVALID,
  // shared read data and status
  output logic [7:0] RDATA,
  output logic       BUSY,
  // RAM side
  output logic       RAM_WEN,
  output logic       RAM_REN,
  output logic [7:0] RAM_WADDR,
  output logic [7:0] RAM_RADDR,
  output logic [7:0] RAM_WD,
  input  logic [7:0] RAM_RD,
  // debug: current FSM state (0 = INIT, 1 = RUN)
  output logic       dbg_state_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // State after reset depends on whether the zero-fill pass is enabled.
  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam logic [7:0] FILL_LAST = 8'hFF;

  state_t     state_q, state_d;
  logic [7:0] fill_q, fill_d;
  // ptr_q = 0 favours A on a tie, 1 favours B.
  logic       ptr_q, ptr_d;
  logic       a_rvalid_q, a_rvalid_d;
  logic       b_rvalid_q, b_rvalid_d;

  logic       run_ok;
  logic       gnt_a, gnt_b;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;

  // Grants are only possible in RUN and never while reset is held.
  assign run_ok = (state_q == ST_RUN) && !RESET;

  // Arbitration: a lone requester wins at once; on a tie the pointer decides.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (run_ok) begin
      if (A_REQ && B_REQ) begin
        gnt_a = !ptr_q;
        gnt_b = ptr_q;
      end else begin
        gnt_a = A_REQ;
        gnt_b = B_REQ;
      end
    end
  end

  // Pick the command of whichever port holds the grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 8'h00;
    sel_wdata = 8'h00;
    if (gnt_a) begin
      sel_we    = A_WE;
      sel_addr  = A_ADDR;
      sel_wdata = A_WDATA;
    end else if (gnt_b) begin
      sel_we    = B_WE;
      sel_addr  = B_ADDR;
      sel_wdata = B_WDATA;
    end
  end

  // FSM next state, fill counter, pointer and RAM command generation.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    ptr_d     = ptr_q;
    BUSY      = 1'b0;
    RAM_WEN   = 1'b0;
    RAM_REN   = 1'b0;
    RAM_WADDR = 8'h00;
    RAM_RADDR = 8'h00;
    RAM_WD    = 8'h00;
    unique case (state_q)
      ST_INIT: begin
        // One zero write per cycle; stop after address 255, no second pass.
        BUSY      = 1'b1;
        RAM_WEN   = !RESET;
        RAM_WADDR = fill_q;
        RAM_WD    = 8'h00;
        if (fill_q == FILL_LAST) begin
          state_d = ST_RUN;
        end else begin
          fill_d = fill_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (gnt_a || gnt_b) begin
          // The winner goes to the back of the line.
          ptr_d = gnt_a;
          if (sel_we) begin
            RAM_WEN   = 1'b1;
            RAM_WADDR = sel_addr;
            RAM_WD    = sel_wdata;
          end else begin
            RAM_REN   = 1'b1;
            RAM_RADDR = sel_addr;
          end
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Read valids follow a read grant by one cycle, matching RAM latency.
  always_comb begin
    a_rvalid_d = gnt_a && !A_WE;
    b_rvalid_d = gnt_b && !B_WE;
  end

  // State register with asynchronous reset.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= RESET_STATE;
      fill_q     <= 8'h00;
      ptr_q      <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      ptr_q      <= ptr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign A_GNT       = gnt_a;
  assign B_GNT       = gnt_b;
  assign A_RVALID    = a_rvalid_q;
  assign B_RVALID    = b_rvalid_q;
  assign RDATA       = RAM_RD;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_core_ram_arbiter.sv
// Bench for core_ram_arbiter: a RAM model, a behavioural arbiter/memory
// reference, directed scenarios and randomized two-port traffic.
module tb_core_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic RWCLK = 1'b0;
  logic RESET;
  always #5 RWCLK = ~RWCLK;

  // ---------------- DUT with zero-fill ----------------
  logic       A_REQ, A_WE, A_GNT, A_RVALID;
  logic [7:0] A_ADDR, A_WDATA;
  logic       B_REQ, B_WE, B_GNT, B_RVALID;
  logic [7:0] B_ADDR, B_WDATA;
  logic [7:0] RDATA;
  logic       BUSY;
  logic       RAM_WEN, RAM_REN;
  logic [7:0] RAM_WADDR, RAM_RADDR, RAM_WD, RAM_RD;
  logic       dbg_state;

  core_ram_arbiter #(.INIT_ZERO(1)) dut (
    .RWCLK(RWCLK), .RESET(RESET),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID),
    .RDATA(RDATA), .BUSY(BUSY),
    .RAM_WEN(RAM_WEN), .RAM_REN(RAM_REN),
    .RAM_WADDR(RAM_WADDR), .RAM_RADDR(RAM_RADDR), .RAM_WD(RAM_WD),
    .RAM_RD(RAM_RD), .dbg_state_o(dbg_state)
  );

  // ---------------- DUT without zero-fill ----------------
  logic       z_a_req, z_a_we, z_a_gnt, z_a_rvalid;
  logic [7:0] z_a_addr, z_a_wdata;
  logic       z_b_gnt, z_b_rvalid;
  logic [7:0] z_rdata;
  logic       z_busy, z_ram_wen, z_ram_ren;
  logic [7:0] z_ram_waddr, z_ram_raddr, z_ram_wd, z_ram_rd;
  logic       z_dbg_state;
  logic       z_zero1;
  logic [7:0] z_zero8;

  core_ram_arbiter #(.INIT_ZERO(0)) dut_nofill (
    .RWCLK(RWCLK), .RESET(RESET),
    .A_REQ(z_a_req), .A_WE(z_a_we), .A_ADDR(z_a_addr), .A_WDATA(z_a_wdata),
    .A_GNT(z_a_gnt), .A_RVALID(z_a_rvalid),
    .B_REQ(z_zero1), .B_WE(z_zero1), .B_ADDR(z_zero8), .B_WDATA(z_zero8),
    .B_GNT(z_b_gnt), .B_RVALID(z_b_rvalid),
    .RDATA(z_rdata), .BUSY(z_busy),
    .RAM_WEN(z_ram_wen), .RAM_REN(z_ram_ren),
    .RAM_WADDR(z_ram_waddr), .RAM_RADDR(z_ram_raddr), .RAM_WD(z_ram_wd),
    .RAM_RD(z_ram_rd), .dbg_state_o(z_dbg_state)
  );

  // ---------------- RAM: 256x8, registered read ----------------
  logic [7:0] ram [256];
  always @(posedge RWCLK) begin
    if (RAM_WEN) ram[RAM_WADDR] <= RAM_WD;
    if (RAM_REN) RAM_RD <= ram[RAM_RADDR];
  end

  // ---------------- scoreboard / reference model ----------------
  int         n_checks;
  int         n_fail;
  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];
  logic       exp_port_q [$];
  logic       last_b;   // 1: B was granted most recently (or after reset)
  logic       g_a, g_b; // model grants of the latest cycle

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_port_q.delete();
    last_b = 1'b1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  task automatic draw_a();
    A_REQ   = ($urandom_range(0, 3) != 0);
    A_WE    = 1'($urandom_range(0, 1));
    A_ADDR  = 8'($urandom_range(0, 15));
    A_WDATA = 8'($urandom_range(0, 255));
  endtask

  task automatic draw_b();
    B_REQ   = ($urandom_range(0, 3) != 0);
    B_WE    = 1'($urandom_range(0, 1));
    B_ADDR  = 8'($urandom_range(0, 15));
    B_WDATA = 8'($urandom_range(0, 255));
  endtask

  // One RUN cycle: compare against the model at negedge, then advance.
  task automatic cycle_check(input bit redraw);
    logic       exp_av, exp_bv, p, we;
    logic [7:0] addr, wd, d;
    @(negedge RWCLK);
    check("busy", BUSY, 0);
    g_a = A_REQ && (!B_REQ || last_b);
    g_b = B_REQ && !g_a;
    check("a_gnt", A_GNT, g_a);
    check("b_gnt", B_GNT, g_b);
    exp_av = 1'b0;
    exp_bv = 1'b0;
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      p = exp_port_q.pop_front();
      if (p) exp_bv = 1'b1; else exp_av = 1'b1;
      check("rdata", RDATA, d);
    end
    check("a_rvalid", A_RVALID, exp_av);
    check("b_rvalid", B_RVALID, exp_bv);
    if (g_a || g_b) begin
      we   = g_a ? A_WE    : B_WE;
      addr = g_a ? A_ADDR  : B_ADDR;
      wd   = g_a ? A_WDATA : B_WDATA;
      if (we) begin
        check("wr_wen", RAM_WEN, 1);
        check("wr_ren", RAM_REN, 0);
        check("wr_waddr", RAM_WADDR, addr);
        check("wr_wd", RAM_WD, wd);
        model_mem[addr] = wd;
      end else begin
        check("rd_ren", RAM_REN, 1);
        check("rd_wen", RAM_WEN, 0);
        check("rd_raddr", RAM_RADDR, addr);
        exp_q.push_back(model_mem[addr]);
        exp_port_q.push_back(g_b);
      end
      last_b = g_b;
    end else begin
      check("idle_wen", RAM_WEN, 0);
      check("idle_ren", RAM_REN, 0);
    end
    @(posedge RWCLK);
    #1;
    if (redraw) begin
      if (g_a || !A_REQ) draw_a();
      if (g_b || !B_REQ) draw_b();
    end
  endtask

  // n cycles of zero-fill, expected addresses counting up from 0.
  task automatic check_fill(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge RWCLK);
      check("fill_busy", BUSY, 1);
      check("fill_wen", RAM_WEN, 1);
      check("fill_ren", RAM_REN, 0);
      check("fill_waddr", RAM_WADDR, i[7:0]);
      check("fill_wd", RAM_WD, 0);
      check("fill_gnt", {A_GNT, B_GNT}, 0);
      check("fill_rvalid", {A_RVALID, B_RVALID}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    model_zero();
    RESET = 1'b1;
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 8'h07; A_WDATA = 8'h00;
    B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = 8'h00; B_WDATA = 8'h00;
    z_a_req = 1'b1; z_a_we = 1'b0; z_a_addr = 8'h22; z_a_wdata = 8'h00;
    z_ram_rd = 8'h00; z_zero1 = 1'b0; z_zero8 = 8'h00;

    // Reset state of both instances, with requests already raised.
    repeat (2) @(posedge RWCLK);
    @(negedge RWCLK);
    check("rst_busy", BUSY, 1);
    check("rst_gnt", {A_GNT, B_GNT}, 0);
    check("rst_ram_en", {RAM_WEN, RAM_REN}, 0);
    check("rst_rvalid", {A_RVALID, B_RVALID}, 0);
    check("nofill_rst_busy", z_busy, 0);
    check("nofill_rst_gnt", z_a_gnt, 0);
    check("nofill_rst_ren", z_ram_ren, 0);

    // Release: no-fill instance grants at once, fill instance writes zeros.
    @(posedge RWCLK);
    #1 RESET = 1'b0;
    #1;
    check("nofill_first_gnt", z_a_gnt, 1);
    check("nofill_busy", z_busy, 0);
    check("nofill_ren", z_ram_ren, 1);
    check("nofill_raddr", z_ram_raddr, 8'h22);
    check_fill(256);

    // First RUN cycle: the held A read is granted, returns filled zero.
    cycle_check(0);
    A_REQ = 1'b0;

    // B alone: four back-to-back reads of 0..3.
    for (int i = 0; i < 4; i++) begin
      B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 8'(i);
      cycle_check(0);
    end
    B_REQ = 1'b0;
    cycle_check(0);

    // A writes 0x5A to 0x10, then reads it back the next cycle.
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 8'h10; A_WDATA = 8'h5A;
    cycle_check(0);
    A_WE = 1'b0;
    cycle_check(0);
    A_REQ = 1'b0;
    cycle_check(0);

    // Both ports requesting every cycle: grants must alternate.
    for (int i = 0; i < 12; i++) begin
      A_REQ = 1'b1; A_WE = 1'($urandom_range(0, 1));
      A_ADDR = 8'($urandom_range(0, 15)); A_WDATA = 8'($urandom_range(0, 255));
      B_REQ = 1'b1; B_WE = 1'($urandom_range(0, 1));
      B_ADDR = 8'($urandom_range(0, 15)); B_WDATA = 8'($urandom_range(0, 255));
      cycle_check(0);
    end

    // Randomized traffic with hold-until-granted requesters.
    draw_a();
    draw_b();
    repeat (600) cycle_check(1);
    A_REQ = 1'b0; B_REQ = 1'b0;
    cycle_check(0);
    cycle_check(0);

    // Reset right after a read grant: no RVALID may follow.
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 8'h03;
    @(negedge RWCLK);
    check("prerst_gnt", A_GNT, 1);
    check("prerst_ren", RAM_REN, 1);
    #2 RESET = 1'b1;
    #1;
    check("async_rst_gnt", A_GNT, 0);
    check("async_rst_ren", RAM_REN, 0);
    check("async_rst_busy", BUSY, 1);
    @(posedge RWCLK);
    #1;
    check("rst_held_gnt", A_GNT, 0);
    check("rst_held_rvalid", A_RVALID, 0);
    A_REQ = 1'b0;
    @(posedge RWCLK);
    #1 RESET = 1'b0;
    model_reset();

    // Reset during fill at count 100: fill restarts from 0 for 256 cycles.
    check_fill(101);
    #2 RESET = 1'b1;
    #1;
    check("midfill_busy", BUSY, 1);
    check("midfill_wen", RAM_WEN, 0);
    @(posedge RWCLK);
    #1 RESET = 1'b0;
    check_fill(256);
    model_zero();

    // After refill, a read of a previously written address returns zero.
    cycle_check(0);
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 8'h05;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 8'h10;
    cycle_check(0);
    A_REQ = 1'b0;
    cycle_check(0);
    B_REQ = 1'b0;
    cycle_check(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
